// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with multi-word blocks, a refill FSM,
// whole-cache flush and saturating hit/miss counters.
module icache_assoc #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2,
  parameter int CNTW  = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  output logic            ihit,
  output logic [31:0]     imemload,
  input  logic            flush,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic            iwait,
  input  logic [31:0]     iload,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);

  localparam int OFFW = $clog2(WORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - OFFW - IDXW;
  localparam int OFFB = (OFFW > 0) ? OFFW : 1;
  localparam int WAYB = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_q, state_d;

  logic [OFFB-1:0] req_off;
  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic            unused_bits;

  assign req_off     = (WORDS > 1) ? imemaddr[2 +: OFFB] : '0;
  assign req_idx     = imemaddr[2+OFFW +: IDXW];
  assign req_tag     = imemaddr[31 -: TAGW];
  assign unused_bits = ^imemaddr[1:0];

  logic [31:0]     data_q  [WAYS][SETS][WORDS];
  logic [TAGW-1:0] tag_q   [WAYS][SETS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYB-1:0] rr_q    [SETS];

  logic [IDXW-1:0] fill_idx_q;
  logic [TAGW-1:0] fill_tag_q;
  logic [WAYB-1:0] fill_way_q;
  logic            fill_by_rr_q;
  logic [OFFB-1:0] cnt_q;

  logic            hit_any;
  logic [WAYB-1:0] hit_way;
  logic [WAYB-1:0] victim;
  logic            victim_by_rr;
  logic            miss_start;
  logic            beat;
  logic            last_beat;
  logic            fill_done;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    hit_any      = 1'b0;
    hit_way      = '0;
    victim       = rr_q[req_idx];
    victim_by_rr = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAYB'(w);
      end
    end
    // Scan downwards so the lowest invalid way wins over the round-robin pick.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        victim       = WAYB'(w);
        victim_by_rr = 1'b0;
      end
    end
  end

  assign miss_start = (state_q == IDLE) && imemREN && !hit_any && !flush;
  assign beat       = (state_q == FILL) && !iwait;
  assign last_beat  = beat && (cnt_q == OFFB'(WORDS - 1));
  assign fill_done  = last_beat && !flush;

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (miss_start) state_d = FILL;
      FILL: if (flush || last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ihit     = nRST && (state_q == IDLE) && imemREN && hit_any && !flush;
    imemload = ihit ? data_q[hit_way][req_idx][req_off] : '0;
    iREN     = (state_q == FILL);
    iaddr    = '0;
    if (iREN) begin
      iaddr = (32'({fill_tag_q, fill_idx_q}) << (OFFW + 2))
            | ((WORDS > 1) ? (32'(cnt_q) << 2) : 32'd0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      fill_way_q   <= '0;
      fill_by_rr_q <= 1'b0;
      cnt_q        <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (ihit && hit_count != '1) hit_count <= hit_count + 1'b1;

      if (miss_start) begin
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
        fill_idx_q   <= req_idx;
        fill_tag_q   <= req_tag;
        fill_way_q   <= victim;
        fill_by_rr_q <= victim_by_rr;
        cnt_q        <= '0;
      end else if (beat) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end else if (fill_done) begin
        valid_q[fill_idx_q][fill_way_q] <= 1'b1;
        if (WAYS > 1 && fill_by_rr_q) rr_q[fill_idx_q] <= rr_q[fill_idx_q] + 1'b1;
      end
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone decide a hit.
  always_ff @(posedge CLK) begin
    if (nRST && beat) begin
      data_q[fill_way_q][fill_idx_q][cnt_q] <= iload;
      if (last_beat) tag_q[fill_way_q][fill_idx_q] <= fill_tag_q;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed scenarios plus random reads
// compared against a per-set FIFO-of-tags reference model.
module tb_icache_assoc;

  localparam int SETS  = 8;
  localparam int WAYS  = 2;
  localparam int WORDS = 2;
  localparam int OFFW  = 1;
  localparam int IDXW  = 3;
  localparam int MISS_LAT = 1 + 3 * WORDS;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST, imemREN, flush, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
  logic [15:0] hit_count, miss_count;

  logic        d_ren, d_flush, d_ihit, d_iren, d_iwait;
  logic [31:0] d_addr, d_load, d_iaddr, d_iload;
  logic [3:0]  d_hits, d_misses;

  icache_assoc #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .CNTW(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_assoc #(.SETS(8), .WAYS(1), .WORDS(2), .CNTW(4)) dut_dm (
    .CLK(CLK), .nRST(nRST), .imemREN(d_ren), .imemaddr(d_addr),
    .ihit(d_ihit), .imemload(d_load), .flush(d_flush), .iREN(d_iren),
    .iaddr(d_iaddr), .iwait(d_iwait), .iload(d_iload),
    .hit_count(d_hits), .miss_count(d_misses)
  );

  logic [31:0] mem_seed;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  // Memory: two busy cycles, then one ready cycle, per beat.
  int wcnt = 0, d_wcnt = 0;
  always @(posedge CLK) begin
    if (!iREN || !iwait) wcnt <= 0;
    else                 wcnt <= wcnt + 1;
    if (!d_iren || !d_iwait) d_wcnt <= 0;
    else                     d_wcnt <= d_wcnt + 1;
  end
  assign iwait   = !(iREN && wcnt == 2);
  assign iload   = mem_word(iaddr);
  assign d_iwait = !(d_iren && d_wcnt == 2);
  assign d_iload = mem_word(d_iaddr);

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int set_q [SETS][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < SETS; s++) set_q[s].delete();
  endtask

  // Round-robin after lowest-invalid filling amounts to FIFO replacement per set.
  task automatic model_access(input logic [31:0] addr, output bit hit);
    int tag, idx;
    tag = int'(addr >> (2 + OFFW + IDXW));
    idx = int'((addr >> (2 + OFFW)) % SETS);
    hit = 1'b0;
    foreach (set_q[idx][i]) if (set_q[idx][i] == tag) hit = 1'b1;
    if (!hit) begin
      if (set_q[idx].size() == WAYS) void'(set_q[idx].pop_front());
      set_q[idx].push_back(tag);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input string tag);
    bit          exp_hit;
    int          n, beat;
    logic [31:0] line;
    model_access(addr, exp_hit);
    line = addr & ~32'(WORDS * 4 - 1);
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = addr;
    n = 0;
    beat = 0;
    @(negedge CLK);
    while (!ihit && n < 60) begin
      if (iREN && !iwait) begin
        check({tag, ".iaddr"}, iaddr, line + 32'(beat * 4));
        beat++;
      end
      @(negedge CLK);
      n++;
    end
    check({tag, ".ihit"}, 32'(ihit), 32'd1);
    check({tag, ".latency"}, 32'(n), exp_hit ? 32'd0 : 32'(MISS_LAT));
    check({tag, ".beats"}, 32'(beat), exp_hit ? 32'd0 : 32'(WORDS));
    check({tag, ".data"}, imemload, mem_word({addr[31:2], 2'b00}));
    exp_hits++;
    if (!exp_hit) exp_misses++;
    @(posedge CLK); #1;
    imemREN = 1'b0;
    check({tag, ".hit_count"}, 32'(hit_count), 32'(exp_hits));
    check({tag, ".miss_count"}, 32'(miss_count), 32'(exp_misses));
  endtask

  task automatic dm_read_drop(input logic [31:0] addr, input string tag);
    int n;
    @(posedge CLK); #1;
    d_ren  = 1'b1;
    d_addr = addr;
    @(posedge CLK); #1;
    d_ren = 1'b0;
    n = 0;
    @(negedge CLK);
    while (d_iren && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check({tag, ".fill_done"}, 32'(d_iren), 32'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] a;
    mem_seed = $urandom;
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0;
    d_ren = 1'b0; d_addr = '0; d_flush = 1'b0;

    // Reset state
    @(negedge CLK);
    check("rst.ihit", 32'(ihit), 32'd0);
    check("rst.imemload", imemload, 32'd0);
    check("rst.iREN", 32'(iREN), 32'd0);
    check("rst.iaddr", iaddr, 32'd0);
    check("rst.hit_count", 32'(hit_count), 32'd0);
    check("rst.miss_count", 32'(miss_count), 32'd0);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    nRST = 1'b1;

    // Cold miss then same-line hit; then FIFO eviction within set 0
    do_read(32'h40, "cold40");
    do_read(32'h44, "hit44");
    do_read(32'h80, "fill80");
    do_read(32'hC0, "fillC0");
    do_read(32'h80, "rehit80");
    do_read(32'h40, "remiss40");
    check("evict.miss_count", 32'(miss_count), 32'd4);

    // Random reads with occasional idle-time flushes
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        @(posedge CLK); #1 flush = 1'b1;
        @(posedge CLK); #1 flush = 1'b0;
        model_flush();
      end
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      a = {24'd0, $urandom_range(0, 63) & 32'h3F, 2'b00};
      do_read(a, "rand");
    end

    // Flush on the first memory beat of a fill for 0x100
    do_read(32'h40, "pre_flush40");
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h100;
    exp_misses++;
    n = 0;
    @(negedge CLK);
    while (!(iREN && !iwait) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check("flush.beat_seen", 32'(iREN && !iwait), 32'd1);
    flush = 1'b1;
    imemREN = 1'b0;
    @(posedge CLK); #1;
    flush = 1'b0;
    model_flush();
    @(negedge CLK);
    check("flush.iREN", 32'(iREN), 32'd0);
    check("flush.iaddr", iaddr, 32'd0);
    check("flush.miss_count", 32'(miss_count), 32'(exp_misses));
    do_read(32'h40, "post_flush40");
    do_read(32'h100, "post_flush100");

    // Reset in the middle of a fill
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h180;
    repeat (3) @(negedge CLK);
    check("rstfill.iREN_before", 32'(iREN), 32'd1);
    nRST = 1'b0;
    #1;
    check("rstfill.ihit", 32'(ihit), 32'd0);
    check("rstfill.imemload", imemload, 32'd0);
    @(posedge CLK); #1;
    check("rstfill.iREN", 32'(iREN), 32'd0);
    check("rstfill.hit_count", 32'(hit_count), 32'd0);
    check("rstfill.miss_count", 32'(miss_count), 32'd0);
    nRST = 1'b1;
    imemREN = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    model_flush();
    do_read(32'h40, "rst_refill40");

    // Direct-mapped instance: conflicting lines always miss; counters saturate at 15
    dm_read_drop(32'h40, "dm40");
    dm_read_drop(32'h80, "dm80");
    dm_read_drop(32'h40, "dm40b");
    check("dm.misses", 32'(d_misses), 32'd3);
    check("dm.hits", 32'(d_hits), 32'd0);
    @(posedge CLK); #1;
    d_ren = 1'b1; d_addr = 32'h44;
    @(negedge CLK);
    check("dm.ihit44", 32'(d_ihit), 32'd1);
    check("dm.data44", d_load, mem_word(32'h44));
    repeat (10) @(posedge CLK);
    #1;
    check("dm.hits10", 32'(d_hits), 32'd10);
    repeat (10) @(posedge CLK);
    #1;
    d_ren = 1'b0;
    check("dm.hits_sat", 32'(d_hits), 32'd15);
    check("dm.misses_final", 32'(d_misses), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
